// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD request controller.
//   GCD_WIDTH : default operand/result width
//   state_e   : request FSM encoding (IDLE/LAUNCH/WAIT/HOLD, 2 bits)
package gcd_pkg;

    localparam int GCD_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/gcd_request_ctrl_if.sv
// Handshake bundle between the GCD initiator and the GCD responder.
//   START  : one-cycle request pulse (initiator -> responder)
//   X_OUT  : latched operand X        (initiator -> responder)
//   Y_OUT  : latched operand Y        (initiator -> responder)
//   DONE   : completion level         (responder -> initiator)
//   GCD_IN : result, valid while DONE (responder -> initiator)
interface gcd_request_ctrl_if import gcd_pkg::*; #(
    parameter int WIDTH = GCD_WIDTH
) ();

    logic             START;
    logic [WIDTH-1:0] X_OUT;
    logic [WIDTH-1:0] Y_OUT;
    logic             DONE;
    logic [WIDTH-1:0] GCD_IN;

    modport master (output START, X_OUT, Y_OUT, input DONE, GCD_IN);
    modport slave  (input START, X_OUT, Y_OUT, output DONE, GCD_IN);

endinterface

// File: rtl/gcd_request_ctrl_btn_debounce.sv
// Push-button debouncer: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on the accepted 0->1 edge of the stable level.
//   CLK     : system clock
//   RESET   : synchronous active-high reset
//   btn_i   : raw asynchronous button, high = pressed
//   press_o : one-cycle pulse when a press is accepted (release gives none)
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic btn_i,
    output logic press_o
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level, so any glitch shorter than DEBOUNCE_CYCLES restarts it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its inputs, independent of order.
        if (RESET) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/gcd_request_ctrl.sv
// GCD initiator: debounces BTN_GO, latches operands, pulses START, waits for
// DONE, then captures and holds the result for display.
//   CLK, RESET            : clock, synchronous active-high reset
//   BTN_GO                : raw push-button
//   X_IN, Y_IN            : operands from switches
//   req (master)          : START/X_OUT/Y_OUT out, DONE/GCD_IN in
//   RESULT, RESULT_VALID  : captured answer and its valid flag
//   BUSY                  : high in LAUNCH/WAIT/HOLD
//   TIMEOUT               : sticky abort flag
// Build option: define GCD_REQ_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES;
// without it WAIT holds indefinitely and TIMEOUT is tied low.
module gcd_request_ctrl import gcd_pkg::*; #(
    parameter int WIDTH           = GCD_WIDTH,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               BTN_GO,
    input  logic [WIDTH-1:0]   X_IN,
    input  logic [WIDTH-1:0]   Y_IN,
    gcd_request_ctrl_if.master req,
    output logic [WIDTH-1:0]   RESULT,
    output logic               RESULT_VALID,
    output logic               BUSY,
    output logic               TIMEOUT
);

    logic             press;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

`ifdef GCD_REQ_TIMEOUT_EN
    localparam int               TMO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK     (CLK),
        .RESET   (RESET),
        .btn_i   (BTN_GO),
        .press_o (press)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        result_d  = result_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
`ifdef GCD_REQ_TIMEOUT_EN
        // Cleared outside WAIT so each WAIT visit counts from zero.
        tmo_d     = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    if (X_IN != '0 && Y_IN != '0) begin
                        x_d       = X_IN;
                        y_d       = Y_IN;
                        valid_d   = 1'b0;
                        timeout_d = 1'b0;
                        state_d   = ST_LAUNCH;
                    end else begin
                        // gcd(0,y)=y and gcd(0,0)=0, so OR gives the answer
                        // without involving the responder.
                        result_d = X_IN | Y_IN;
                        valid_d  = 1'b1;
                    end
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (req.DONE) begin
                    result_d = req.GCD_IN;
                    valid_d  = 1'b1;
                    state_d  = ST_HOLD;
                end
`ifdef GCD_REQ_TIMEOUT_EN
                else if (tmo_q == TMO_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            // Wait for DONE to drop so a stale level cannot complete the
            // next request.
            ST_HOLD: if (!req.DONE) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef GCD_REQ_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
`ifdef GCD_REQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    // START is decoded from the state register, so it lasts exactly the one
    // LAUNCH cycle and drops with any reset.
    assign req.START    = (state_q == ST_LAUNCH);
    assign req.X_OUT    = x_q;
    assign req.Y_OUT    = y_q;
    assign RESULT       = result_q;
    assign RESULT_VALID = valid_q;
    assign BUSY         = (state_q != ST_IDLE);
`ifdef GCD_REQ_TIMEOUT_EN
    assign TIMEOUT      = timeout_q;
`else
    assign TIMEOUT      = 1'b0;
`endif

endmodule
